// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-side consumer of the async byte FIFO (clkb domain).
// Pops bytes, packs them LSB-first into NBYTE-wide words and presents them on
// a valid/ready port with per-byte keep flags. A flush pulse pushes out a
// partial word so trailing bytes are never stranded.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_FILL | popping bytes from the FIFO and writing them into lane cnt
//   S_OUT  | word presented on wvalid, held stable until wready accepts it
module fifo_rd_packer #(
   parameter int NBYTE = 4,
   parameter int DW    = 8
) (
   input  logic                clkb,
   input  logic                rstb,
   input  logic                emptyb,
   input  logic [DW-1:0]       rdatb,
   output logic                rreqb,
   input  logic                flushb,
   output logic                wvalid,
   input  logic                wready,
   output logic [NBYTE*DW-1:0] wdata,
   output logic [NBYTE-1:0]    wkeep,
   output logic [3:0]          pk_cnt
);

   localparam int          LW  = (NBYTE > 1) ? $clog2(NBYTE) : 1;
   localparam logic [3:0]  NB4 = 4'(NBYTE);

   typedef enum logic {S_FILL, S_OUT} st_t;

   st_t            st, st_nxt;
   logic [3:0]     cnt, cnt_nxt;
   logic           rd_pend, rd_pend_nxt;
   logic           fl_pend, fl_pend_nxt;
   logic [LW-1:0]  lane;
   logic [NBYTE-1:0] keep_nxt;

   assign lane   = cnt[LW-1:0];
   assign pk_cnt = cnt;

   // State register: FSM state plus fill count and pending flags.
   always_ff @(posedge clkb or posedge rstb) begin
      if (rstb) begin
         st      <= S_FILL;
         cnt     <= '0;
         rd_pend <= 1'b0;
         fl_pend <= 1'b0;
      end else begin
         st      <= st_nxt;
         cnt     <= cnt_nxt;
         rd_pend <= rd_pend_nxt;
         fl_pend <= fl_pend_nxt;
      end
   end

   // Next-state: the FILL exit looks at post-capture values so wvalid rises
   // the cycle right after the last byte lands.
   always_comb begin
      st_nxt      = st;
      cnt_nxt     = cnt;
      rd_pend_nxt = rreqb;
      fl_pend_nxt = fl_pend;
      case (st)
         S_FILL: begin
            if (rd_pend)
               cnt_nxt = cnt + 4'd1;
            if (flushb && ((cnt != 4'd0) || rd_pend))
               fl_pend_nxt = 1'b1;
            if (!rd_pend_nxt &&
                ((cnt_nxt == NB4) || (fl_pend_nxt && (cnt_nxt != 4'd0))))
               st_nxt = S_OUT;
         end
         S_OUT: begin
            if (wvalid && wready) begin
               st_nxt      = S_FILL;
               cnt_nxt     = '0;
               fl_pend_nxt = 1'b0;
            end
         end
         default: st_nxt = S_FILL;
      endcase
   end

   // Output decode: pop request is combinational so emptyb stops it at once.
   always_comb begin
      rreqb = 1'b0;
      if (!rstb && (st == S_FILL))
         rreqb = ~emptyb & ~fl_pend & ((cnt + 4'(rd_pend)) < NB4);
      for (int k = 0; k < NBYTE; k++)
         keep_nxt[k] = (4'(k) < cnt_nxt);
   end

   // Word datapath: capture into lane cnt, latch keep on exit, clear on accept.
   always_ff @(posedge clkb or posedge rstb) begin
      if (rstb) begin
         wvalid <= 1'b0;
         wdata  <= '0;
         wkeep  <= '0;
      end else begin
         wvalid <= (st_nxt == S_OUT);
         if ((st == S_FILL) && rd_pend) begin
            for (int k = 0; k < NBYTE; k++)
               if (lane == LW'(k))
                  wdata[k*DW +: DW] <= rdatb;
         end
         if ((st == S_FILL) && (st_nxt == S_OUT))
            wkeep <= keep_nxt;
         if ((st == S_OUT) && wvalid && wready) begin
            wdata <= '0;
            wkeep <= '0;
         end
      end
   end

endmodule
